// File: rtl/dccm_port_arbiter_pkg.sv
// Shared owner type and default sizing for the DCCM port arbiter.
// No logic; types and constants only.
// Not applicable: no flow control lives here.
package dccm_port_arbiter_pkg;

   // Which requester a DCCM read belongs to, kept in issue order.
   typedef enum logic {
      OWN_LSU = 1'b0,
      OWN_DMA = 1'b1
   } dccm_owner_e;

   localparam int DCCM_XLEN       = 32;
   localparam int DCCM_STARVE_MAX = 4;
   localparam int DCCM_RQ_DEPTH   = 2;

   // Pointer width that stays legal for a single-entry queue.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dccm_owner_fifo.sv
// In-order 1-bit owner queue: records who issued each outstanding DCCM read.
// Head valid combinationally; push/pop take effect on the clock edge.
// Push while full and pop while empty are ignored; a pop does not free a slot for a same-cycle push.
module dccm_owner_fifo
   import dccm_port_arbiter_pkg::*;
#(
   parameter int DEPTH = DCCM_RQ_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_own,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   localparam int AW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage needs no reset: entries are only read once the count says they exist.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_own;
      end
   end

   // Pointers and occupancy; reset flushes everything outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dccm_port_arbiter.sv
// Shares the DCCM read and write ports between LSU and DMA; LSU priority with a DMA starvation override.
// Requests and returns are combinational (zero added latency); arbitration state updates on clk.
// Losers are held off via lsu_stall / deasserted dma_gnt; reads also stall when the owner queue is full.
module dccm_port_arbiter
   import dccm_port_arbiter_pkg::*;
#(
   parameter int XLEN       = DCCM_XLEN,
   parameter int STARVE_MAX = DCCM_STARVE_MAX,
   parameter int RQ_DEPTH   = DCCM_RQ_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lsu_raddr,
   input  logic            lsu_rvalid_in,
   output logic [XLEN-1:0] lsu_rdata,
   output logic            lsu_rvalid_out,
   input  logic [XLEN-1:0] lsu_waddr,
   input  logic [XLEN-1:0] lsu_wdata,
   input  logic            lsu_wen,
   output logic            lsu_stall,
   input  logic            dma_req,
   input  logic            dma_we,
   input  logic [XLEN-1:0] dma_addr,
   input  logic [XLEN-1:0] dma_wdata,
   output logic            dma_gnt,
   output logic [XLEN-1:0] dma_rdata,
   output logic            dma_rvalid,
   output logic [XLEN-1:0] dccm_raddr,
   output logic            dccm_rvalid_in,
   input  logic [XLEN-1:0] dccm_rdata,
   input  logic            dccm_rvalid_out,
   output logic [XLEN-1:0] dccm_waddr,
   output logic [XLEN-1:0] dccm_wdata,
   output logic            dccm_wen,
   output logic            rd_err
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_cnt;
   logic          dma_force;
   logic          dma_rd;
   logic          dma_wr;
   logic          lsu_rd_gnt;
   logic          dma_rd_gnt;
   logic          lsu_wr_gnt;
   logic          dma_wr_gnt;
   logic          q_full;
   logic          q_empty;
   logic          q_head;
   dccm_owner_e   push_own;
   dccm_owner_e   head_own;
   logic          ret_ok;

   assign dma_rd    = dma_req & ~dma_we;
   assign dma_wr    = dma_req &  dma_we;
   assign dma_force = (starve_cnt == SW'(STARVE_MAX));

   // Per-port grants: LSU wins a conflict unless DMA has starved long enough; reads need a queue slot.
   always_comb begin
      lsu_rd_gnt = lsu_rvalid_in & ~q_full & ~(dma_rd & dma_force);
      dma_rd_gnt = dma_rd & ~q_full & (~lsu_rvalid_in | dma_force);
      lsu_wr_gnt = lsu_wen & ~(dma_wr & dma_force);
      dma_wr_gnt = dma_wr & (~lsu_wen | dma_force);
   end

   assign dma_gnt   = dma_rd_gnt | dma_wr_gnt;
   assign lsu_stall = (lsu_rvalid_in & ~lsu_rd_gnt) | (lsu_wen & ~lsu_wr_gnt);

   // Steer the winner onto each DCCM port; an idle port drives zeros.
   always_comb begin
      dccm_raddr     = '0;
      dccm_rvalid_in = lsu_rd_gnt | dma_rd_gnt;
      dccm_waddr     = '0;
      dccm_wdata     = '0;
      dccm_wen       = lsu_wr_gnt | dma_wr_gnt;
      if (lsu_rd_gnt)      dccm_raddr = lsu_raddr;
      else if (dma_rd_gnt) dccm_raddr = dma_addr;
      if (lsu_wr_gnt) begin
         dccm_waddr = lsu_waddr;
         dccm_wdata = lsu_wdata;
      end else if (dma_wr_gnt) begin
         dccm_waddr = dma_addr;
         dccm_wdata = dma_wdata;
      end
   end

   assign push_own = dma_rd_gnt ? OWN_DMA : OWN_LSU;

   dccm_owner_fifo #(
      .DEPTH (RQ_DEPTH)
   ) u_owner_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (dccm_rvalid_in),
      .push_own (logic'(push_own)),
      .pop      (dccm_rvalid_out),
      .head     (q_head),
      .full     (q_full),
      .empty    (q_empty)
   );

   assign head_own = dccm_owner_e'(q_head);
   assign ret_ok   = dccm_rvalid_out & ~q_empty;

   // Route each return to whoever issued the oldest outstanding read; orphan returns are dropped.
   always_comb begin
      lsu_rvalid_out = 1'b0;
      lsu_rdata      = '0;
      dma_rvalid     = 1'b0;
      dma_rdata      = '0;
      if (ret_ok) begin
         if (head_own == OWN_LSU) begin
            lsu_rvalid_out = 1'b1;
            lsu_rdata      = dccm_rdata;
         end else begin
            dma_rvalid = 1'b1;
            dma_rdata  = dccm_rdata;
         end
      end
   end

   // Count consecutive cycles a requesting DMA was turned away, saturating at the override level.
   always_ff @(posedge clk) begin
      if (rst || !dma_req || dma_gnt) begin
         starve_cnt <= '0;
      end else if (!dma_force) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Sticky flag for a return with nothing outstanding (e.g. after a mid-flight reset).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_err <= 1'b0;
      end else if (dccm_rvalid_out && q_empty) begin
         rd_err <= 1'b1;
      end
   end

endmodule
